// File: rtl/adc_dac_scheduler.sv
// Sample-period sequencer: tick generation, ADC conversion starts, result capture, DAC load.
// Optional conversion timeout enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_dac_scheduler #(
    parameter int unsigned DIV     = 4999,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] ch_mask,
    input  logic       clr_err,
    output logic       adc_start,
    output logic       adc_channel,
    input  logic       adc_valid,
    input  logic [9:0] adc_data,
    output logic [9:0] ch0_data,
    output logic [9:0] ch1_data,
    output logic       sample_valid,
    input  logic [9:0] dac_data_in,
    output logic       dac_start,
    output logic [9:0] dac_data,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int unsigned CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_SAMPLE,
        S_DAC
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_ch1_en;
    logic        r_adc_start;
    logic        r_adc_channel;
    logic [9:0]  r_ch0_data;
    logic [9:0]  r_ch1_data;
    logic        r_sample_valid;
    logic        r_dac_start;
    logic [9:0]  r_dac_data;
    logic        r_overrun;
    logic        w_tick;

    assign w_tick = enable && (r_cnt == CW'(DIV));

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] r_tcnt;
    logic          r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_ch1_en       <= 1'b0;
            r_adc_start    <= 1'b0;
            r_adc_channel  <= 1'b0;
            r_ch0_data     <= '0;
            r_ch1_data     <= '0;
            r_sample_valid <= 1'b0;
            r_dac_start    <= 1'b0;
            r_dac_data     <= '0;
            r_overrun      <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            r_tcnt         <= '0;
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            r_adc_start    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_dac_start    <= 1'b0;

            // Error set is written after the clear so a coincident event wins.
            if (clr_err) begin
                r_overrun <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
                r_timeout_err <= 1'b0;
`endif
            end
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick && (ch_mask != '0)) begin
                        r_ch1_en      <= ch_mask[1];
                        r_adc_channel <= ~ch_mask[0];
                        r_adc_start   <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
`ifdef ADC_SCHED_TIMEOUT_EN
                    r_tcnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc_valid) begin
                        if (r_adc_channel) begin
                            r_ch1_data <= adc_data;
                        end else begin
                            r_ch0_data <= adc_data;
                        end
                        if (!r_adc_channel && r_ch1_en) begin
                            r_adc_channel <= 1'b1;
                            r_adc_start   <= 1'b1;
                            r_state       <= S_START;
                        end else begin
                            r_sample_valid <= 1'b1;
                            r_state        <= S_SAMPLE;
                        end
                    end
`ifdef ADC_SCHED_TIMEOUT_EN
                    else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
`endif
                end
                S_SAMPLE: begin
                    r_dac_data  <= dac_data_in;
                    r_dac_start <= 1'b1;
                    r_state     <= S_DAC;
                end
                S_DAC: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_start    = r_adc_start;
    assign adc_channel  = r_adc_channel;
    assign ch0_data     = r_ch0_data;
    assign ch1_data     = r_ch1_data;
    assign sample_valid = r_sample_valid;
    assign dac_start    = r_dac_start;
    assign dac_data     = r_dac_data;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule
